// File: rtl/mux_inst_issue.sv
// Drain stage for the 8-wide instruction FIFO: pops one 8-entry group,
// stages it locally and issues it one instruction per cycle.
module mux_inst_issue #(
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_0,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_1,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_2,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_3,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_4,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_5,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_6,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_7,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd,
    input  logic                  flush,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [FIFO_WIDTH-1:0] issue_inst,
    output logic [2:0]            issue_idx,
    output logic                  issue_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  issued_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]            r_state;
    logic [2:0]            r_idx;
    logic [FIFO_WIDTH-1:0] r_stage [8];
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [FIFO_WIDTH-1:0] w_rdata [8];
    logic                  w_in_issue;
    logic                  w_valid;
    logic                  w_hs;
    logic                  w_at_last;
    logic                  w_load;

    assign w_rdata[0] = fifo_rdata_0;
    assign w_rdata[1] = fifo_rdata_1;
    assign w_rdata[2] = fifo_rdata_2;
    assign w_rdata[3] = fifo_rdata_3;
    assign w_rdata[4] = fifo_rdata_4;
    assign w_rdata[5] = fifo_rdata_5;
    assign w_rdata[6] = fifo_rdata_6;
    assign w_rdata[7] = fifo_rdata_7;

    assign w_in_issue = (r_state == S_ISSUE);
    assign w_at_last  = (r_idx == 3'd7);
    assign w_valid    = ~rst & ~flush & w_in_issue;
    assign w_hs       = w_valid & issue_ready;

    // Reload on the last handshake keeps the issue stream bubble-free.
    assign w_load = ~rst & ~flush & ~fifo_almost_empty &
                    (~w_in_issue | (w_hs & w_at_last));

    assign fifo_rd     = w_load;
    assign issue_valid = w_valid;
    assign issue_inst  = r_stage[r_idx];
    assign issue_idx   = r_idx;
    assign issue_last  = w_valid & w_at_last;
    assign busy        = w_in_issue;
    assign issued_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_stage[i] <= '0;
            end
        end else if (flush) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
        end else begin
            if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                for (int i = 0; i < 8; i++) begin
                    r_stage[i] <= w_rdata[i];
                end
                r_idx   <= 3'd0;
                r_state <= S_ISSUE;
            end else if (w_hs) begin
                if (w_at_last) begin
                    r_state <= S_IDLE;
                    r_idx   <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_inst_issue.sv
// Bench for mux_inst_issue: queue-based FIFO and issue model,
// directed vector tables and a randomized soak.
module tb_mux_inst_issue;

    logic        clk;
    logic        rst;
    logic [31:0] rdw [8];
    logic        ae;
    logic        fifo_rd;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_inst;
    logic [2:0]  issue_idx;
    logic        issue_last;
    logic        busy;
    logic [3:0]  issued_cnt;

    mux_inst_issue #(.FIFO_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .fifo_rdata_0(rdw[0]), .fifo_rdata_1(rdw[1]),
        .fifo_rdata_2(rdw[2]), .fifo_rdata_3(rdw[3]),
        .fifo_rdata_4(rdw[4]), .fifo_rdata_5(rdw[5]),
        .fifo_rdata_6(rdw[6]), .fifo_rdata_7(rdw[7]),
        .fifo_almost_empty(ae), .fifo_rd(fifo_rd),
        .flush(flush), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_inst(issue_inst),
        .issue_idx(issue_idx), .issue_last(issue_last),
        .busy(busy), .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          fl;
        bit          ev;
        bit          erd;
        bit          ebusy;
        logic [2:0]  eidx;
        logic [31:0] einst;
        logic [3:0]  ecnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] fq[$];
    logic [31:0] pend[$];
    logic [3:0]  m_cnt;

    logic        s_rd, s_valid, s_last, s_busy;
    logic [31:0] s_inst;
    logic [2:0]  s_idx;
    logic [3:0]  s_cnt;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < 8; i++) begin
            rdw[i] = (i < fq.size()) ? fq[i] : 32'h0;
        end
        ae = (fq.size() <= 8);
    endtask

    // One cycle: predict from queues, compare, then advance the model.
    task automatic step();
        logic [31:0] win [8];
        bit mv, hs, ml;
        int sz;
        drive_fifo();
        @(negedge clk);
        sz = pend.size();
        mv = !rst && !flush && sz > 0;
        hs = mv && issue_ready;
        ml = !rst && !flush && fq.size() > 8 &&
             (sz == 0 || (hs && sz == 1));
        s_rd = fifo_rd; s_valid = issue_valid; s_last = issue_last;
        s_busy = busy; s_inst = issue_inst; s_idx = issue_idx;
        s_cnt = issued_cnt;
        chk("fifo_rd", 32'(s_rd), 32'(ml));
        chk("issue_valid", 32'(s_valid), 32'(mv));
        chk("issue_last", 32'(s_last), 32'(mv && sz == 1));
        chk("busy", 32'(s_busy), 32'(sz > 0));
        chk("issued_cnt", 32'(s_cnt), 32'(m_cnt));
        if (mv) begin
            chk("issue_inst", s_inst, pend[0]);
            chk("issue_idx", 32'(s_idx), 32'(8 - sz));
        end
        for (int i = 0; i < 8; i++) begin
            win[i] = (i < fq.size()) ? fq[i] : 32'h0;
        end
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_cnt = 4'd0;
        end else if (flush) begin
            pend.delete();
        end else begin
            if (hs) begin
                void'(pend.pop_front());
                m_cnt = m_cnt + 4'd1;
            end
            if (ml) begin
                pend.delete();
                for (int i = 0; i < 8; i++) pend.push_back(win[i]);
            end
        end
        if (s_rd) begin
            for (int i = 0; i < 8; i++) begin
                if (fq.size() > 0) void'(fq.pop_front());
            end
        end
        #1;
    endtask

    task automatic chk_vec(vec_t v, string tag);
        chk({tag, "_valid"}, 32'(s_valid), 32'(v.ev));
        chk({tag, "_rd"}, 32'(s_rd), 32'(v.erd));
        chk({tag, "_busy"}, 32'(s_busy), 32'(v.ebusy));
        chk({tag, "_cnt"}, 32'(s_cnt), 32'(v.ecnt));
        if (v.ev) begin
            chk({tag, "_idx"}, 32'(s_idx), 32'(v.eidx));
            chk({tag, "_inst"}, s_inst, v.einst);
        end
    endtask

    task automatic push_grp(logic [31:0] base);
        for (int i = 0; i < 8; i++) fq.push_back(base + 32'(i));
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(s_busy), 32'(0));
        rst = 1'b0;
    endtask

    vec_t tv_drain [10];
    vec_t tv_flush [7];

    initial begin
        int nrd, nv, nhs;
        tv_drain[0] = '{1, 0, 0, 1, 0, 3'd0, 32'h0, 4'd0};
        for (int k = 0; k < 8; k++) begin
            tv_drain[k+1] = '{1, 0, 1, 0, 1, 3'(k), 32'h100 + 32'(k), 4'(k)};
        end
        tv_drain[9] = '{1, 0, 0, 0, 0, 3'd0, 32'h0, 4'd8};
        tv_flush[0] = '{1, 0, 0, 1, 0, 3'd0, 32'h0,   4'd0};
        tv_flush[1] = '{1, 0, 1, 0, 1, 3'd0, 32'h300, 4'd0};
        tv_flush[2] = '{1, 0, 1, 0, 1, 3'd1, 32'h301, 4'd1};
        tv_flush[3] = '{1, 0, 1, 0, 1, 3'd2, 32'h302, 4'd2};
        tv_flush[4] = '{1, 1, 0, 0, 1, 3'd3, 32'h0,   4'd3};
        tv_flush[5] = '{1, 0, 0, 1, 0, 3'd0, 32'h0,   4'd3};
        tv_flush[6] = '{1, 0, 1, 0, 1, 3'd0, 32'h400, 4'd3};

        m_cnt = 4'd0;
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
        drive_fifo();
        @(posedge clk); #1;

        // Reset with a ready FIFO, then single group drain.
        push_grp(32'h100); fq.push_back(32'hdead);
        do_reset();
        chk("rst_cnt", 32'(s_cnt), 32'(0));
        chk("rst_rd", 32'(s_rd), 32'(0));
        for (int i = 0; i < 10; i++) begin
            issue_ready = tv_drain[i].rdy; flush = tv_drain[i].fl;
            step();
            chk_vec(tv_drain[i], "drain");
        end

        // Backpressure with ready pattern 1,0,0.
        fq.delete(); push_grp(32'h200); fq.push_back(32'hbeef);
        do_reset();
        step();
        nhs = 0;
        for (int j = 0; j < 40 && nhs < 8; j++) begin
            issue_ready = (j % 3 == 0);
            step();
            if (s_valid && issue_ready) nhs++;
        end
        chk("bp_handshakes", 32'(nhs), 32'(8));
        issue_ready = 1'b0;
        step();
        chk("bp_cnt", 32'(s_cnt), 32'(8));

        // Back-to-back reload of groups A and B.
        fq.delete(); push_grp(32'ha0); push_grp(32'hb0);
        fq.push_back(32'h1);
        do_reset();
        step();
        nv = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (s_valid) nv++;
            if (k == 8) chk("b2b_rd_at_last", 32'(s_rd), 32'(1));
            if (k == 9) chk("b2b_b0", s_inst, 32'hb0);
        end
        chk("b2b_valid_cycles", 32'(nv), 32'(16));

        // Flush mid-group.
        fq.delete(); push_grp(32'h300); push_grp(32'h400);
        fq.push_back(32'h2);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue_ready = tv_flush[i].rdy; flush = tv_flush[i].fl;
            step();
            chk_vec(tv_flush[i], "flush");
        end
        flush = 1'b0;

        // Almost-empty hold: exactly 8 entries never pop.
        fq.delete(); push_grp(32'h500);
        do_reset();
        nrd = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_rd) nrd++;
        end
        chk("ae_no_pop", 32'(nrd), 32'(0));

        // Counter wrap with a 4-bit counter.
        fq.delete(); push_grp(32'h600); push_grp(32'h700);
        push_grp(32'h800); fq.push_back(32'h3);
        do_reset();
        issue_ready = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            step();
            if (k == 16) chk("wrap_15", 32'(s_cnt), 32'(15));
            if (k == 17) chk("wrap_0", 32'(s_cnt), 32'(0));
            if (k == 18) chk("wrap_1", 32'(s_cnt), 32'(1));
        end

        // Randomized soak against the queue model.
        fq.delete();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                if (fq.size() < 64) fq.push_back($urandom);
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
